imem_loader: RTL and testbench

Writer side of the byte-addressed instruction memory. Accepts 32-bit instruction words over a valid/ready stream and serializes each word into four consecutive little-endian byte writes on a byte-wide memory write port, so that a later 32-bit fetch at the word's address returns the original word. It sits between a program source (UART receiver, debug port or testbench) and the instruction memory's write port, and it runs before the core is released from reset.

---
 rtl/imem_pkg.sv | 15 +
 rtl/word_to_byte_serializer.sv | 39 +++
 rtl/imem_loader.sv | 125 ++++++++++++
 tb/tb_imem_loader.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared constants and the loader state type for the instruction-memory loader.
package imem_pkg;

   localparam int unsigned DEF_DATA_LENGTH = 32;
   localparam int unsigned DEF_MEM_SIZE    = 256;
   localparam int unsigned BYTES_PER_WORD  = 4;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_WRITE,
      ST_DONE
   } imem_loader_state_t;

endpackage

// File: rtl/word_to_byte_serializer.sv
// Latches one stream word plus its last flag and walks a lane counter over its bytes,
// least-significant byte first.
module word_to_byte_serializer
   import imem_pkg::*;
(
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          i_load,
   input  logic                          i_advance,
   input  logic [BYTES_PER_WORD*8-1:0]   i_data,
   input  logic                          i_last,
   output logic [7:0]                    o_byte,
   output logic                          o_last_lane,
   output logic                          o_word_last
);

   logic [BYTES_PER_WORD*8-1:0]         r_word;
   logic                                r_last;
   logic [$clog2(BYTES_PER_WORD)-1:0]   r_lane;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_word <= '0;
         r_last <= 1'b0;
         r_lane <= '0;
      end else if (i_load) begin
         r_word <= i_data;
         r_last <= i_last;
         r_lane <= '0;
      end else if (i_advance) begin
         r_lane <= r_lane + 1'b1;
      end
   end

   assign o_byte      = r_word[{r_lane, 3'b000} +: 8];
   assign o_last_lane = &r_lane;
   assign o_word_last = r_last;

endmodule

// File: rtl/imem_loader.sv
// Stream-to-byte-port instruction memory loader: FSM, address counter and sticky flags.
// Optional running byte checksum port enabled by IMEM_LOADER_CHECKSUM_EN.
module imem_loader
   import imem_pkg::*;
#(
   parameter int unsigned DATA_LENGTH = DEF_DATA_LENGTH,
   parameter int unsigned MEM_SIZE    = DEF_MEM_SIZE
)
(
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         start,
   input  logic                         s_valid,
   input  logic [DATA_LENGTH-1:0]       s_data,
   input  logic                         s_last,
   output logic                         s_ready,
   output logic                         mem_we,
   output logic [$clog2(MEM_SIZE)-1:0]  mem_addr,
   output logic [7:0]                   mem_din,
   output logic                         busy,
   output logic                         done,
   output logic                         full
`ifdef IMEM_LOADER_CHECKSUM_EN
   ,
   output logic [7:0]                   checksum
`endif
);

   localparam int unsigned AW = $clog2(MEM_SIZE);

   imem_loader_state_t r_state, w_next;
   logic [AW-1:0]      r_addr;
   logic               r_done;
   logic               r_full;
   logic               w_accept;
   logic               w_wr;
   logic [7:0]         w_byte;
   logic               w_last_lane;
   logic               w_word_last;

   word_to_byte_serializer u_ser (
      .clk         (clk),
      .rst         (rst),
      .i_load      (w_accept),
      .i_advance   (w_wr),
      .i_data      (s_data),
      .i_last      (s_last),
      .o_byte      (w_byte),
      .o_last_lane (w_last_lane),
      .o_word_last (w_word_last)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next   = r_state;
      s_ready  = 1'b0;
      mem_we   = 1'b0;
      busy     = 1'b0;
      w_accept = 1'b0;
      w_wr     = 1'b0;
      unique case (r_state)
         ST_IDLE: ;
         ST_LOAD: begin
            s_ready  = 1'b1;
            busy     = 1'b1;
            w_accept = s_valid && !start;
            if (s_valid) w_next = ST_WRITE;
         end
         ST_WRITE: begin
            mem_we = 1'b1;
            busy   = 1'b1;
            w_wr   = 1'b1;
            // all-ones address on the last lane means the increment wraps: memory full
            if (w_last_lane)
               w_next = (w_word_last || (&r_addr)) ? ST_DONE : ST_LOAD;
         end
         ST_DONE: ;
      endcase
      if (start) w_next = ST_LOAD;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_addr <= '0;
         r_done <= 1'b0;
         r_full <= 1'b0;
      end else if (start) begin
         r_addr <= '0;
         r_done <= 1'b0;
         r_full <= 1'b0;
      end else if (w_wr) begin
         r_addr <= r_addr + 1'b1;
         if (w_last_lane) begin
            if (w_word_last) begin
               r_done <= 1'b1;
            end else if (&r_addr) begin
               r_done <= 1'b1;
               r_full <= 1'b1;
            end
         end
      end
   end

   assign mem_addr = r_addr;
   assign mem_din  = mem_we ? w_byte : '0;
   assign done     = r_done;
   assign full     = r_full;

`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0] r_checksum;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)       r_checksum <= '0;
      else if (start) r_checksum <= '0;
      else if (w_wr)  r_checksum <= r_checksum + w_byte;
   end

   assign checksum = r_checksum;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader against a transaction-level model of the byte stream.
module tb_imem_loader;

   localparam int unsigned MSZ = 16;
   localparam int unsigned AW  = $clog2(MSZ);

   logic          clk;
   logic          rst;
   logic          start;
   logic          s_valid;
   logic [31:0]   s_data;
   logic          s_last;
   logic          s_ready;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [7:0]    mem_din;
   logic          busy;
   logic          done;
   logic          full;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]    checksum;
`endif

   int unsigned vectors = 0;
   int unsigned errors  = 0;

   // reference model state
   int unsigned m_addr;
   int unsigned m_sum;
   bit          m_done;
   bit          m_full;

   imem_loader #(.DATA_LENGTH(32), .MEM_SIZE(MSZ)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .s_valid  (s_valid),
      .s_data   (s_data),
      .s_last   (s_last),
      .s_ready  (s_ready),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .mem_din  (mem_din),
      .busy     (busy),
      .done     (done),
      .full     (full)
`ifdef IMEM_LOADER_CHECKSUM_EN
      ,
      .checksum (checksum)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_status(input string tag);
      check_val({tag, "_done"},  32'(done),     32'(m_done));
      check_val({tag, "_full"},  32'(full),     32'(m_full));
      check_val({tag, "_ready"}, 32'(s_ready),  32'(!m_done));
      check_val({tag, "_busy"},  32'(busy),     32'(!m_done));
      check_val({tag, "_we"},    32'(mem_we),   32'(0));
      check_val({tag, "_addr"},  32'(mem_addr), m_addr);
`ifdef IMEM_LOADER_CHECKSUM_EN
      check_val({tag, "_csum"},  32'(checksum), m_sum % 256);
`endif
   endtask

   task automatic model_start();
      m_addr = 0;
      m_sum  = 0;
      m_done = 0;
      m_full = 0;
   endtask

   // pulse start at a negedge; sampled on the following posedge
   task automatic start_load();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      model_start();
      check_status("start");
   endtask

   // present one word; abort_lane >= 0 pulses start during that WRITE lane
   task automatic send_word(input logic [31:0] d, input logic l, input int gap,
                            input bit hold, input int abort_lane);
      int n;
      logic [7:0] exp_b;
      if (!s_valid) begin
         repeat (gap) begin
            check_val("gap_we", 32'(mem_we), 32'(0));
            check_val("gap_ready", 32'(s_ready), 32'(1));
            @(negedge clk);
         end
      end
      s_valid = 1'b1;
      s_data  = d;
      s_last  = l;
      n = 0;
      while (s_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check_val("ready_wait", 32'(s_ready), 32'(1));
      if (s_ready !== 1'b1) begin
         s_valid = 1'b0;
         return;
      end
      @(negedge clk);
      if (!hold) s_valid = 1'b0;
      for (int lane = 0; lane < 4; lane++) begin
         exp_b = 8'((d >> (8 * lane)) & 32'hFF);
         check_val("wr_we",    32'(mem_we),   32'(1));
         check_val("wr_addr",  32'(mem_addr), m_addr);
         check_val("wr_din",   32'(mem_din),  32'(exp_b));
         check_val("wr_ready", 32'(s_ready),  32'(0));
         check_val("wr_busy",  32'(busy),     32'(1));
         m_sum  = m_sum + exp_b;
         m_addr = (m_addr + 1) % MSZ;
         if (lane == abort_lane) begin
            s_valid = 1'b0;
            start_load();
            return;
         end
         @(negedge clk);
      end
      if (l) m_done = 1;
      else if (m_addr == 0) begin
         m_done = 1;
         m_full = 1;
      end
      check_status("post");
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      logic [31:0] w;
      int nw;
      rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
      model_start();
      #3;
      check_val("rst_ready", 32'(s_ready),  32'(0));
      check_val("rst_we",    32'(mem_we),   32'(0));
      check_val("rst_addr",  32'(mem_addr), 32'(0));
      check_val("rst_din",   32'(mem_din),  32'(0));
      check_val("rst_busy",  32'(busy),     32'(0));
      check_val("rst_done",  32'(done),     32'(0));
      check_val("rst_full",  32'(full),     32'(0));
`ifdef IMEM_LOADER_CHECKSUM_EN
      check_val("rst_csum",  32'(checksum), 32'(0));
`endif
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      s_valid = 1'b1;
      @(negedge clk); @(negedge clk);
      check_val("idle_ready", 32'(s_ready), 32'(0));
      check_val("idle_we",    32'(mem_we),  32'(0));
      s_valid = 1'b0;

      // single final word
      start_load();
      send_word(32'hDEADBEEF, 1'b1, 0, 1'b0, -1);
      s_valid = 1'b1;
      repeat (2) @(negedge clk);
      check_val("done_hold_ready", 32'(s_ready), 32'(0));
      check_val("done_hold_we",    32'(mem_we),  32'(0));
      s_valid = 1'b0;

      // back-to-back with valid held high
      start_load();
      send_word(32'h11223344, 1'b0, 0, 1'b1, -1);
      send_word(32'h55667788, 1'b1, 0, 1'b0, -1);

      // fill the memory without s_last
      start_load();
      for (int i = 0; i < 4; i++) send_word(32'hC0DE0000 + 32'(i), 1'b0, 0, 1'b1, -1);
      s_valid = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check_val("full_ready", 32'(s_ready), 32'(0));
         check_val("full_flag",  32'(full),    32'(1));
      end
      s_valid = 1'b0;

      // restart in the second write cycle
      start_load();
      send_word(32'hAABBCCDD, 1'b0, 0, 1'b0, 1);
      send_word(32'h01020304, 1'b0, 1, 1'b0, -1);

      // start wins over a word presented in LOAD
      s_valid = 1'b1;
      s_data  = 32'hFFFF0000;
      start_load();
      check_val("startwin_we", 32'(mem_we), 32'(0));
      s_valid = 1'b0;

      // checksum example
      start_load();
      send_word(32'h01020304, 1'b0, 0, 1'b0, -1);
      send_word(32'h000000FF, 1'b1, 0, 1'b0, -1);
`ifdef IMEM_LOADER_CHECKSUM_EN
      check_val("csum_example", 32'(checksum), 32'h09);
`endif

      // asynchronous reset mid-write
      start_load();
      s_valid = 1'b1; s_data = 32'h12345678; s_last = 1'b0;
      @(negedge clk);
      s_valid = 1'b0;
      check_val("arst_pre_we", 32'(mem_we), 32'(1));
      @(negedge clk);
      #1 rst = 1'b1;
      #1;
      check_val("arst_we",    32'(mem_we),   32'(0));
      check_val("arst_ready", 32'(s_ready),  32'(0));
      check_val("arst_busy",  32'(busy),     32'(0));
      check_val("arst_done",  32'(done),     32'(0));
      check_val("arst_addr",  32'(mem_addr), 32'(0));
      @(negedge clk);
      rst = 1'b0;
      model_start();
      @(negedge clk);
      check_val("arst_idle_ready", 32'(s_ready), 32'(0));
      check_val("arst_idle_busy",  32'(busy),    32'(0));

      // randomized programs
      for (int p = 0; p < 25; p++) begin
         start_load();
         nw = int'($urandom_range(1, 6));
         for (int k = 0; k < nw && !m_done; k++) begin
            w = $urandom;
            send_word(w, (k == nw - 1) && ($urandom_range(0, 3) != 0),
                      int'($urandom_range(0, 2)),
                      (k < nw - 1) && ($urandom_range(0, 1) == 1),
                      ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1);
         end
         s_valid = 1'b0;
         @(negedge clk);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
